// File: rtl/flappy_button_poller_pkg.sv
// Shared definitions for masters that poll the button PIO: FSM encoding and register map.
// Combinational only; no latency or backpressure of its own.
package flappy_button_poller_pkg;

    typedef logic [1:0] avm_addr_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_EVAL = 2'd3;

    localparam avm_addr_t BTN_DATA_ADDR = 2'd0;

endpackage

// File: rtl/flappy_button_poller_if.sv
// Avalon-MM read-only link between a polling master and the button PIO.
// Fixed read latency 1; the slave stalls a read through avm_waitrequest.
interface flappy_button_poller_if;
    import flappy_button_poller_pkg::*;

    avm_addr_t   avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata
    );

endinterface

// File: rtl/flappy_debounce.sv
// Debounces one polled sample per i_sample_vld; flap pulse registered one cycle after the accepting sample.
// No backpressure: every strobed sample is consumed in its cycle.
module flappy_debounce #(
    parameter int DEBOUNCE_CNT = 4,
    parameter bit PRESS_LEVEL  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sample_vld,
    input  logic        i_sample,
    output logic        o_btn_pressed,
    output logic        o_flap_pulse,
    output logic [15:0] o_press_count
);

    localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_CNT);

    logic        r_cand;
    logic [3:0]  r_stable;
    logic        r_btn;
    logic        r_pulse;
    logic [15:0] r_press_count;

    logic       w_cand_nxt;
    logic [3:0] w_stable_nxt;
    logic       w_level_pressed;
    logic       w_accept;
    logic       w_press;

    always_comb begin
        w_cand_nxt   = r_cand;
        w_stable_nxt = r_stable;
        if (i_sample == r_cand) begin
            if (r_stable < STABLE_MAX)
                w_stable_nxt = r_stable + 4'd1;
        end else begin
            w_cand_nxt   = i_sample;
            w_stable_nxt = 4'd1;
        end
        w_level_pressed = (w_cand_nxt == PRESS_LEVEL);
        w_accept        = i_sample_vld && (w_stable_nxt == STABLE_MAX) && (w_level_pressed != r_btn);
        w_press         = w_accept && w_level_pressed;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cand        <= ~PRESS_LEVEL;
            r_stable      <= 4'd0;
            r_btn         <= 1'b0;
            r_pulse       <= 1'b0;
            r_press_count <= 16'd0;
        end else begin
            // Only presses pulse; a pulse can never repeat because r_btn flips on the same edge.
            r_pulse <= w_press;
            if (i_sample_vld) begin
                r_cand   <= w_cand_nxt;
                r_stable <= w_stable_nxt;
            end
            if (w_accept)
                r_btn <= w_level_pressed;
            if (w_press)
                r_press_count <= r_press_count + 16'd1;
        end
    end

    assign o_btn_pressed = r_btn;
    assign o_flap_pulse  = r_pulse;
    assign o_press_count = r_press_count;

endmodule

// File: rtl/flappy_button_poller.sv
// Polls the button PIO every POLL_DIV clocks and debounces it into a one-cycle flap pulse.
// Press-to-pulse (DEBOUNCE_CNT-1)*POLL_DIV+3 clocks; waitrequest stalls REQ, a poll that expires meanwhile is deferred.
module flappy_button_poller
    import flappy_button_poller_pkg::*;
#(
    parameter int POLL_DIV     = 500,
    parameter int DEBOUNCE_CNT = 4,
    parameter bit PRESS_LEVEL  = 1'b0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_poll_en,
    flappy_button_poller_if.master        avm,
    output logic                          o_btn_pressed,
    output logic                          o_flap_pulse,
    output logic [15:0]                   o_press_count
);

    localparam int            TW     = $clog2(POLL_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(POLL_DIV - 1);

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic          r_pending;
    logic          r_sample;

    logic w_expire;
    logic w_sample_vld;
    logic w_unused_rdata;

    assign w_expire       = (r_timer == '0);
    assign w_sample_vld   = (r_state == ST_EVAL);
    assign w_unused_rdata = ^avm.avm_readdata[31:1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= RELOAD;
            r_pending <= 1'b0;
            r_sample  <= 1'b0;
        end else begin
            // Timer runs during a transaction; an expiry there is remembered in r_pending.
            if (r_state == ST_IDLE && !i_poll_en) begin
                r_timer   <= RELOAD;
                r_pending <= 1'b0;
            end else begin
                r_timer <= w_expire ? RELOAD : r_timer - TW'(1);
                if (r_state == ST_IDLE)
                    r_pending <= 1'b0;
                else if (w_expire)
                    r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: if (i_poll_en && (w_expire || r_pending)) r_state <= ST_REQ;
                ST_REQ:  if (!avm.avm_waitrequest) r_state <= ST_WAIT;
                ST_WAIT: begin
                    r_sample <= avm.avm_readdata[0];
                    r_state  <= ST_EVAL;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign avm.avm_read    = (r_state == ST_REQ);
    assign avm.avm_address = BTN_DATA_ADDR;

    flappy_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .PRESS_LEVEL  (PRESS_LEVEL)
    ) u_deb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_sample_vld  (w_sample_vld),
        .i_sample      (r_sample),
        .o_btn_pressed (o_btn_pressed),
        .o_flap_pulse  (o_flap_pulse),
        .o_press_count (o_press_count)
    );

endmodule
